// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the control decoder:
// next-PC select encodings and the fetch FSM state type.
package ifu_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_REG    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_e;

endpackage

// File: rtl/ifu_npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, region jump
// or register target. All arithmetic wraps modulo 2^32.
module npc_calc
  import ifu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] instr_idx_i,
  input  logic [31:0] reg_target_i,
  input  logic [1:0]  npc_op_i,
  output logic [31:0] npc_o
);

  logic [31:0] branch_off;

  // Branch offset is a signed word count relative to the delay-free pc+4.
  assign branch_off = {{14{instr_idx_i[15]}}, instr_idx_i[15:0], 2'b00};

  always_comb begin
    npc_o = pc_plus4_i;
    case (npc_op_i)
      NPC_PLUS4:  npc_o = pc_plus4_i;
      NPC_BRANCH: npc_o = pc_plus4_i + branch_off;
      NPC_JUMP:   npc_o = {pc_plus4_i[31:28], instr_idx_i, 2'b00};
      NPC_REG:    npc_o = reg_target_i & 32'hFFFF_FFFC;
      default:    npc_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per retirement over a
// req/ready handshake, and closes the PC loop through npc_calc.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [1:0]  npc_op,
  input  logic [31:0] reg_target
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        im_req_q;
  logic        instr_valid_q;
  logic [31:0] npc_d;

  npc_calc u_npc_calc (
    .pc_plus4_i   (pc_plus4),
    .instr_idx_i  (instr_q[25:0]),
    .reg_target_i (reg_target),
    .npc_op_i     (npc_op),
    .npc_o        (npc_d)
  );

  // Handshake outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      im_req_q      <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= FETCH;
          im_req_q <= 1'b1;
        end
        FETCH: begin
          if (im_ready) begin
            instr_q       <= im_rdata;
            state_q       <= EXEC;
            im_req_q      <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (retire) begin
            pc_q          <= npc_d;
            state_q       <= FETCH;
            im_req_q      <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          im_req_q      <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign im_req      = im_req_q;
  assign im_addr     = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, sequential/branch/jump/jr fetches, wait
// states, ignored retire, async reset mid-fetch, and PC wrap on a second copy.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk;
  logic        rst;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        retire;
  logic [1:0]  npc_op;
  logic [31:0] reg_target;

  logic        im_req,  im_req2;
  logic [31:0] im_addr, im_addr2;
  logic [31:0] instr,   instr2;
  logic        instr_valid, instr_valid2;
  logic [5:0]  op, op2, funct, funct2;
  logic [31:0] pc, pc2, pc_plus4, pc_plus4_2;

  int vectors;
  int miscompares;

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr),
    .im_ready(im_ready), .im_rdata(im_rdata), .instr(instr),
    .instr_valid(instr_valid), .op(op), .funct(funct), .pc(pc),
    .pc_plus4(pc_plus4), .retire(retire), .npc_op(npc_op),
    .reg_target(reg_target)
  );

  // Wrap copy shares all stimulus with the main instance.
  ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .im_req(im_req2), .im_addr(im_addr2),
    .im_ready(im_ready), .im_rdata(im_rdata), .instr(instr2),
    .instr_valid(instr_valid2), .op(op2), .funct(funct2), .pc(pc2),
    .pc_plus4(pc_plus4_2), .retire(retire), .npc_op(npc_op),
    .reg_target(reg_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in EXEC; returns at the negedge after the retire edge.
  task automatic do_retire(input logic [1:0] sel, input logic [31:0] tgt,
                           input logic [31:0] exp_addr, input string tag);
    retire     = 1'b1;
    npc_op     = sel;
    reg_target = tgt;
    @(negedge clk);
    retire = 1'b0;
    check({tag, ".im_req"}, {31'd0, im_req}, 32'd1);
    check({tag, ".im_addr"}, im_addr, exp_addr);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  // Called at a negedge in FETCH with im_ready high at the next edge.
  task automatic do_fetch(input logic [31:0] word, input string tag);
    im_rdata = word;
    im_ready = 1'b1;
    @(negedge clk);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, ".instr"}, instr, word);
    check({tag, ".im_req"}, {31'd0, im_req}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    im_ready    = 1'b1;
    im_rdata    = 32'h2008_0005;
    retire      = 1'b0;
    npc_op      = NPC_PLUS4;
    reg_target  = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.pc", pc, 32'h0000_3000);
    check("rst.instr", instr, 32'h0);
    check("rst.im_req", {31'd0, im_req}, 32'd0);
    check("rst.valid", {31'd0, instr_valid}, 32'd0);
    check("rst.im_addr", im_addr, 32'h0000_3000);
    check("rst.op", {26'd0, op}, 32'd0);
    check("rst.funct", {26'd0, funct}, 32'd0);
    check("rst.pc_plus4", pc_plus4, 32'h0000_3004);
    check("rst.wrap_pc_plus4", pc_plus4_2, 32'h0000_0000);
    rst = 1'b0;

    @(negedge clk);
    check("first.im_req", {31'd0, im_req}, 32'd1);
    check("first.im_addr", im_addr, 32'h0000_3000);
    check("first.valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("first.exec_valid", {31'd0, instr_valid}, 32'd1);
    check("first.op", {26'd0, op}, 32'h08);
    check("first.funct", {26'd0, funct}, 32'h05);
    check("first.im_req_low", {31'd0, im_req}, 32'd0);

    do_retire(NPC_PLUS4, 32'h0, 32'h0000_3004, "seq1");
    check("wrap.im_addr", im_addr2, 32'h0000_0000);
    do_fetch(32'h0000_0000, "seq1f");
    do_retire(NPC_PLUS4, 32'h0, 32'h0000_3008, "seq2");
    do_fetch(32'h0000_0000, "seq2f");
    do_retire(NPC_PLUS4, 32'h0, 32'h0000_300C, "seq3");
    do_fetch(32'h0000_0000, "seq3f");
    do_retire(NPC_PLUS4, 32'h0, 32'h0000_3010, "seq4");
    do_fetch(32'h1000_FFFF, "brf");
    check("br.pc_plus4", pc_plus4, 32'h0000_3014);
    do_retire(NPC_BRANCH, 32'h0, 32'h0000_3010, "branch");
    do_fetch(32'h0800_0C10, "jf");
    check("j.op", {26'd0, op}, 32'h02);
    do_retire(NPC_JUMP, 32'h0, 32'h0000_3040, "jump");
    do_fetch(32'h0000_0008, "jrf");
    im_ready = 1'b0;  // hold the following fetch in wait states
    do_retire(NPC_REG, 32'h0000_3057, 32'h0000_3054, "jr");

    for (int i = 0; i < 4; i++) begin
      retire = (i == 1);
      npc_op = NPC_JUMP;
      @(negedge clk);
      retire = 1'b0;
      check($sformatf("wait%0d.im_req", i), {31'd0, im_req}, 32'd1);
      check($sformatf("wait%0d.im_addr", i), im_addr, 32'h0000_3054);
      check($sformatf("wait%0d.valid", i), {31'd0, instr_valid}, 32'd0);
    end
    check("wait.instr_held", instr, 32'h0000_0008);
    do_fetch(32'h2009_0001, "waitf");
    check("waitf.pc", pc, 32'h0000_3054);

    im_ready = 1'b0;
    do_retire(NPC_PLUS4, 32'h0, 32'h0000_3058, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("arst.pc", pc, 32'h0000_3000);
    check("arst.im_req", {31'd0, im_req}, 32'd0);
    check("arst.instr", instr, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    im_ready = 1'b1;
    @(negedge clk);
    check("arst.refetch_req", {31'd0, im_req}, 32'd1);
    check("arst.refetch_addr", im_addr, 32'h0000_3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core: holds the PC and fetches one instruction per retirement from instruction memory over a request/ready handshake. It presents the fetched word, plus its `op`/`funct` fields, to the control decoder. It takes the decoder's next-PC selection back to compute the following PC. The block sits directly upstream of the control decoder and closes the PC loop around it.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `im_req` out 1: fetch request to instruction memory.
- `im_addr` out 32: fetch address; equals `pc`, bits [1:0] always 0.
- `im_ready` in 1: memory accepts the request and returns `im_rdata` in the same cycle.
- `im_rdata` in 32: fetched instruction word.
- `instr` out 32: registered current instruction.
- `instr_valid` out 1: `instr` is valid and executing.
- `op` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, used as the link value for jal/jalr.
- `retire` in 1: the core finished the current instruction; the next PC is taken this cycle.
- `npc_op` in 2: next-PC select. 00 PLUS4, 01 BRANCH, 10 JUMP, 11 REG.
- `reg_target` in 32: rs value for jr/jalr.

## Operation
- FSM states: IDLE, FETCH, EXEC.
  - IDLE → FETCH unconditionally on the next cycle.
  - FETCH → EXEC when `im_ready`=1.
  - EXEC → FETCH when `retire`=1.
- IDLE behaviour: `im_req`=0, `instr_valid`=0.
- FETCH behaviour:
  - `im_req`=1, with `im_addr`=`pc` held stable until `im_ready`.
  - On `im_ready`, `instr` ← `im_rdata`.
- EXEC behaviour:
  - `instr_valid`=1 and `im_req`=0.
  - On `retire`, `pc` ← npc.
- Next-PC computation, all arithmetic mod 2^32 (wraps silently):
  - PLUS4: `pc_plus4`.
  - BRANCH: `pc_plus4` + (sign_extend(`instr[15:0]`) << 2).
  - JUMP: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - REG: {`reg_target[31:2]`, 2'b00}; low bits are dropped with no fault.
- `op`, `funct` and `pc_plus4` are combinational from the `instr`/`pc` registers.
- Ignored inputs:
  - `retire` outside EXEC is ignored.
  - `im_ready` outside FETCH is ignored.
  - `npc_op` and `reg_target` are sampled only in the cycle where `retire`=1 in EXEC.

## Timing
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `instr`=0.
  - `instr_valid`=0, `im_req`=0, `im_addr`=`RESET_PC`.
  - `op`=0, `funct`=0, `pc_plus4`=`RESET_PC`+4.
- First `im_req` is asserted on the first cycle after `rst` deasserts, one cycle after IDLE.
- Fetch latency: `instr_valid` rises the cycle after `im_ready` is sampled high. With memory that is always ready, there is one FETCH cycle per instruction.
- Retire to next request: `pc` updates at the retire edge, and `im_req` rises with the new `im_addr` in the following cycle.
- Minimum cycles per instruction is 2 (FETCH + EXEC).
- Wait states: `im_ready`=0 keeps the FSM in FETCH indefinitely. `instr` and `pc` stay unchanged while waiting.
- Reset mid-operation: asynchronous return to the reset values in any state. A pending fetch is abandoned, and memory must tolerate `im_req` dropping without `im_ready`.
- PC wrap: `pc`=32'hFFFF_FFFC with PLUS4 gives 32'h0000_0000.

## Structure
- Shared package `ifu_pkg` holds:
  - NPC constants NPC_PLUS4=2'b00, NPC_BRANCH=2'b01, NPC_JUMP=2'b10, NPC_REG=2'b11. The control decoder uses the same encodings.
  - State encoding IDLE/FETCH/EXEC.
- One combinational sub-module, `npc_calc`:
  - Inputs: `pc_plus4`, `instr[25:0]`, `reg_target`, `npc_op`.
  - Output: the 32-bit next PC.
- The `ifu` top holds the FSM, the `pc` register and the `instr` register.

## Test plan
- **Reset and first fetch:** hold `rst` 3 cycles, then release with `im_ready`=1 and `im_rdata`=32'h2008_0005.
  - Cycle 1 after release: `im_req`=1, `im_addr`=32'h0000_3000.
  - Next cycle: `instr_valid`=1, `op`=6'h08.
- **Sequential fetch:** three retires with `npc_op`=00 → `im_addr` sequence 3004, 3008, 300C.
- **Branch:** `instr`=32'h1000_FFFF at `pc` 32'h0000_3010, retire with `npc_op`=01 → next `im_addr`=32'h0000_3010.
- **Jump and jr:**
  - `instr`=32'h0800_0C10, `npc_op`=10 → `im_addr`=32'h0000_3040.
  - `npc_op`=11 with `reg_target`=32'h0000_3057 → `im_addr`=32'h0000_3054.
- **Wait states and ignored inputs:** `im_ready` low for 4 cycles.
  - `im_req` stays high, `im_addr` stays stable, `instr_valid` stays 0.
  - `retire` pulsed during FETCH has no effect.
- **Async reset mid-fetch, and wrap:**
  - `rst` pulse while in FETCH → `pc`=32'h0000_3000 and `im_req`=0 immediately.
  - Separately, a run with `RESET_PC`=32'hFFFF_FFFC and PLUS4 → next `im_addr`=0.
